// File: rtl/edge_pix_out.sv
// edge_pix_out: buffers edge-magnitude samples in a small FIFO and streams
// them out as RGB565 pixels over a valid/ready handshake, tagging the first
// pixel of each frame (pix_sof) and the last pixel of each line (pix_eol).
// The edge stage cannot be stalled, so a sample arriving while the FIFO is
// full is dropped and the sticky overflow flag is raised.
// Optional feature: define EDGE_THRESH_EN to binarize pixels against thresh
// (white when magnitude >= thresh, black otherwise) instead of grayscale.
module edge_pix_out #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        edge_valid,
    input  logic [7:0]  edge_magnitude,
    input  logic [7:0]  thresh,
    input  logic        ov_clr,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic handshake;
    logic drop;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // The output register reloads whenever it is empty or its pixel is taken.
    assign pop        = !fifo_empty && (!pix_valid || pix_ready);
    // A full FIFO still accepts a sample when a pop frees a slot this cycle.
    assign push       = edge_valid && (!fifo_full || pop);
    assign drop       = edge_valid && fifo_full && !pop;
    assign handshake  = pix_valid && pix_ready;

`ifdef EDGE_THRESH_EN
    // Binarized pixel: white at or above the threshold, black below it.
    function automatic logic [15:0] to_pixel(input logic [7:0] m);
        return (m >= thresh) ? 16'hFFFF : 16'h0000;
    endfunction
`else
    // Grayscale RGB565: replicate the magnitude's MSBs into each channel.
    function automatic logic [15:0] to_pixel(input logic [7:0] m);
        return {m[7:3], m[7:2], m[7:3]};
    endfunction

    // thresh only matters when binarization is built in.
    logic unused_thresh;
    assign unused_thresh = ^thresh;
`endif

    // FIFO storage write port.
    // NOTE: the storage array has no reset; emptiness is tracked by count and
    // the pointers, so clearing the data itself would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= edge_magnitude;
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    // Output register: load on pop, empty after a handshake with nothing queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else if (pop) begin
            pix_valid <= 1'b1;
            pix_data  <= to_pixel(mem[rd_ptr]);
        end else if (handshake) begin
            pix_valid <= 1'b0;
        end
    end

    // Raster position of the pixel in the output register; moves on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (handshake) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // One-cycle pulse once the last pixel of the frame has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= handshake && (col == COL_LAST) && (row == ROW_LAST);
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ov_clr) begin
            overflow <= 1'b0;
        end
    end

    assign pix_sof = pix_valid && (col == '0) && (row == '0);
    assign pix_eol = pix_valid && (col == COL_LAST);

endmodule

// File: tb/tb_edge_pix_out.sv
// tb_edge_pix_out: directed bench for edge_pix_out at 4x2 pixels, FIFO depth 4.
// Define EDGE_THRESH_EN for both bench and RTL to exercise binarization.
`timescale 1ns/1ps
module tb_edge_pix_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        edge_valid;
    logic [7:0]  edge_magnitude;
    logic [7:0]  thresh;
    logic        ov_clr;
    logic        pix_ready;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic        overflow;

    int n_checks = 0;
    int n_fails  = 0;

    edge_pix_out #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .edge_valid    (edge_valid),
        .edge_magnitude(edge_magnitude),
        .thresh        (thresh),
        .ov_clr        (ov_clr),
        .pix_ready     (pix_ready),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Expected pixel for a magnitude under the build's mapping.
    function automatic logic [15:0] exp_pix(input logic [7:0] m);
`ifdef EDGE_THRESH_EN
        return (m >= 8'h40) ? 16'hFFFF : 16'h0000;
`else
        return {m[7:3], m[7:2], m[7:3]};
`endif
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edge_valid = 1'b0;
        edge_magnitude = 8'h00;
        ov_clr = 1'b0;
        pix_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        edge_valid = 1'b0;
        edge_magnitude = 8'h00;
        thresh = 8'h40;
        ov_clr = 1'b0;
        pix_ready = 1'b0;
        #3;
        n_checks++;
        if ({pix_valid, pix_data, pix_sof, pix_eol, frame_done, overflow} !== 21'd0) begin
            n_fails++;
            $display("FAIL reset_outputs: got v=%b d=%h sof=%b eol=%b fd=%b ov=%b, expected all 0",
                     pix_valid, pix_data, pix_sof, pix_eol, frame_done, overflow);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Four magnitudes back to back with pix_ready high.
    task automatic test_stream();
        logic [7:0]  mags [4] = '{8'h00, 8'h80, 8'hFF, 8'h47};
`ifdef EDGE_THRESH_EN
        logic [15:0] exps [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
        logic [15:0] exps [4] = '{16'h0000, 16'h8410, 16'hFFFF, 16'h4228};
`endif
        do_reset();
        pix_ready = 1'b1;
        edge_valid = 1'b1;
        edge_magnitude = mags[0];
        tick();
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL stream_no_bypass: pix_valid=%b, expected 0", pix_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) edge_magnitude = mags[i+1];
            else       edge_valid = 1'b0;
            tick();
            n_checks++;
            if ({pix_valid, pix_data, pix_sof, pix_eol} !== {1'b1, exps[i], i == 0, i == 3}) begin
                n_fails++;
                $display("FAIL stream_beat%0d: got v=%b d=%h sof=%b eol=%b, expected v=1 d=%h sof=%b eol=%b",
                         i, pix_valid, pix_data, pix_sof, pix_eol, exps[i], i == 0, i == 3);
            end
        end
        tick();
        n_checks++;
        if ({pix_valid, frame_done} !== 2'b00) begin
            n_fails++;
            $display("FAIL stream_drained: got v=%b fd=%b, expected 0 0", pix_valid, frame_done);
        end
    endtask

    // Fill while stalled, drop on full, clear priority, write-with-pop when full.
    task automatic test_overflow();
        logic [7:0] drain [5] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h70};
        do_reset();
        pix_ready = 1'b0;
        edge_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_magnitude = 8'(8'h10 * (i + 1));
            tick();
        end
        n_checks++;
        if ({pix_valid, pix_data, overflow} !== {1'b1, exp_pix(8'h10), 1'b0}) begin
            n_fails++;
            $display("FAIL ovf_filled: got v=%b d=%h ov=%b, expected v=1 d=%h ov=0",
                     pix_valid, pix_data, overflow, exp_pix(8'h10));
        end
        edge_magnitude = 8'h60;
        tick();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_set: overflow=%b, expected 1", overflow);
        end
        edge_magnitude = 8'h61;
        ov_clr = 1'b1;
        tick();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_set_wins: overflow=%b, expected 1", overflow);
        end
        edge_valid = 1'b0;
        tick();
        ov_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_clear: overflow=%b, expected 0", overflow);
        end
        pix_ready = 1'b1;
        edge_valid = 1'b1;
        edge_magnitude = 8'h70;
        for (int i = 0; i < 5; i++) begin
            tick();
            edge_valid = 1'b0;
            n_checks++;
            if ({pix_valid, pix_data, overflow} !== {1'b1, exp_pix(drain[i]), 1'b0}) begin
                n_fails++;
                $display("FAIL ovf_drain%0d: got v=%b d=%h ov=%b, expected v=1 d=%h ov=0",
                         i, pix_valid, pix_data, overflow, exp_pix(drain[i]));
            end
        end
        tick();
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_empty: pix_valid=%b, expected 0", pix_valid);
        end
    endtask

    // Full 8-pixel frame with pix_ready pattern 1,0,0,1.
    task automatic test_back_to_back();
        logic [7:0] vals [8] = '{8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5};
        bit         pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        int         hs = 0;
        logic       pend;
        logic       stalled;
        logic [15:0] held;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            edge_valid = (t < 8);
            edge_magnitude = (t < 8) ? vals[t] : 8'h00;
            pix_ready = pat[t % 4];
            pend = pix_valid && pix_ready;
            stalled = pix_valid && !pix_ready;
            held = pix_data;
            tick();
            if (pend) hs++;
            n_checks++;
            if (frame_done !== (pend && hs == 8)) begin
                n_fails++;
                $display("FAIL frame_done_t%0d: got %b, expected %b", t, frame_done, pend && hs == 8);
            end
            if (stalled) begin
                n_checks++;
                if ({pix_valid, pix_data} !== {1'b1, held}) begin
                    n_fails++;
                    $display("FAIL stall_hold_t%0d: got v=%b d=%h, expected v=1 d=%h",
                             t, pix_valid, pix_data, held);
                end
            end
            if (pix_valid && hs < 8) begin
                n_checks++;
                if ({pix_data, pix_sof, pix_eol} !== {exp_pix(vals[hs]), hs == 0, hs % 4 == 3}) begin
                    n_fails++;
                    $display("FAIL order_px%0d: got d=%h sof=%b eol=%b, expected d=%h sof=%b eol=%b",
                             hs, pix_data, pix_sof, pix_eol, exp_pix(vals[hs]), hs == 0, hs % 4 == 3);
                end
            end
            if (hs == 8 && !pend) break;
        end
        n_checks++;
        if (hs !== 8) begin
            n_fails++;
            $display("FAIL frame_handshakes: got %0d, expected 8", hs);
        end
        pix_ready = 1'b0;
        edge_valid = 1'b1;
        edge_magnitude = 8'h77;
        tick();
        edge_valid = 1'b0;
        tick();
        n_checks++;
        if ({pix_valid, pix_sof, pix_eol} !== 3'b110) begin
            n_fails++;
            $display("FAIL next_frame_sof: got v=%b sof=%b eol=%b, expected 1 1 0",
                     pix_valid, pix_sof, pix_eol);
        end
    endtask

    // Threshold input: binarizes when built in, ignored otherwise.
    task automatic test_thresh();
        logic [7:0]  mags [3] = '{8'h3F, 8'h40, 8'hC0};
`ifdef EDGE_THRESH_EN
        logic [15:0] exps [3] = '{16'h0000, 16'hFFFF, 16'hFFFF};
`else
        logic [15:0] exps [3] = '{16'h39E7, 16'h4208, 16'hC618};
`endif
        do_reset();
        thresh = 8'h40;
        pix_ready = 1'b1;
        edge_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_valid = (i < 3);
            edge_magnitude = (i < 3) ? mags[i] : 8'h00;
            tick();
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if ({pix_valid, pix_data} !== {1'b1, exps[i-1]}) begin
                    n_fails++;
                    $display("FAIL thresh_px%0d: got v=%b d=%h, expected v=1 d=%h",
                             i - 1, pix_valid, pix_data, exps[i-1]);
                end
            end
        end
    endtask

    // Reset mid-frame with one pixel in the register and one in the FIFO.
    task automatic test_reset_mid();
        do_reset();
        pix_ready = 1'b0;
        edge_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_magnitude = 8'(8'h90 + i);
            tick();
        end
        edge_valid = 1'b0;
        pix_ready = 1'b1;
        tick();
        tick();
        tick();
        pix_ready = 1'b0;
        n_checks++;
        if ({pix_valid, pix_data} !== {1'b1, exp_pix(8'h93)}) begin
            n_fails++;
            $display("FAIL mid_pre_reset: got v=%b d=%h, expected v=1 d=%h",
                     pix_valid, pix_data, exp_pix(8'h93));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_data, pix_sof, pix_eol, frame_done, overflow} !== 21'd0) begin
            n_fails++;
            $display("FAIL mid_async_reset: got v=%b d=%h sof=%b eol=%b fd=%b ov=%b, expected all 0",
                     pix_valid, pix_data, pix_sof, pix_eol, frame_done, overflow);
        end
        tick();
        rst_n = 1'b1;
        pix_ready = 1'b1;
        tick();
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_fifo_flushed: pix_valid=%b, expected 0", pix_valid);
        end
        edge_valid = 1'b1;
        edge_magnitude = 8'h99;
        tick();
        edge_valid = 1'b0;
        tick();
        n_checks++;
        if ({pix_valid, pix_data, pix_sof} !== {1'b1, exp_pix(8'h99), 1'b1}) begin
            n_fails++;
            $display("FAIL mid_restart_sof: got v=%b d=%h sof=%b, expected v=1 d=%h sof=1",
                     pix_valid, pix_data, pix_sof, exp_pix(8'h99));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_thresh();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/edge_pix_out.md
EDGE_PIX_OUT -- requirements
Module: edge_pix_out

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per output line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per output frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 4: magnitude buffer entries.
REQ-004 SHALL have port clk, input, 1: single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port edge_valid, input, 1: magnitude sample strobe from the edge stage; no backpressure.
REQ-007 SHALL have port edge_magnitude, input, 8: unsigned edge magnitude, sampled when edge_valid=1.
REQ-008 SHALL have port thresh, input, 8: binarization threshold, quasi-static.
REQ-009 SHALL have port ov_clr, input, 1: clears overflow flag.
REQ-010 SHALL have port pix_ready, input, 1: downstream accepts pixel.
REQ-011 SHALL have port pix_valid, output, 1: pix_data holds a valid pixel.
REQ-012 SHALL have port pix_data, output, 16: RGB565 pixel.
REQ-013 SHALL have port pix_sof, output, 1: qualifies pix_data as first pixel of frame (col 0, row 0).
REQ-014 SHALL have port pix_eol, output, 1: qualifies pix_data as last pixel of a line.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse after last pixel of frame is accepted.
REQ-016 SHALL have port overflow, output, 1: sticky flag, sample dropped.

Function
REQ-017 SHALL write edge_magnitude into the FIFO on every cycle with edge_valid=1 unless FIFO full and no pop that cycle.
REQ-018 SHALL, on write to a full FIFO with no simultaneous pop, drop the sample, keep FIFO contents, and set overflow next edge.
REQ-019 SHALL accept a write to a full FIFO when a pop occurs the same cycle; occupancy unchanged.
REQ-020 SHALL provide no empty-FIFO bypass; an input written on edge N earliest sets pix_valid=1 after edge N+1.
REQ-021 SHALL pop FIFO into output register when FIFO non-empty and (pix_valid=0 or pix_ready=1).
REQ-022 SHALL hold pix_valid, pix_data, pix_sof, pix_eol stable while pix_valid=1 and pix_ready=0.
REQ-023 SHALL deassert pix_valid after a handshake (pix_valid&pix_ready) when FIFO empty.
REQ-024 SHALL sustain one pixel per cycle when FIFO non-empty and pix_ready held high.
REQ-025 SHALL map magnitude m to pix_data = {m[7:3], m[7:2], m[7:3]} (grayscale RGB565) when binarization compiled out.
REQ-026 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) of the pixel in the output register, advancing only on handshake.
REQ-027 SHALL wrap col to 0 and increment row at col=IMG_WIDTH-1; wrap row to 0 at row=IMG_HEIGHT-1 end of line.
REQ-028 SHALL drive pix_sof=1 iff col=0 and row=0, pix_eol=1 iff col=IMG_WIDTH-1, both gated by pix_valid.
REQ-029 SHALL pulse frame_done for exactly one cycle on the edge following handshake of col=IMG_WIDTH-1, row=IMG_HEIGHT-1.
REQ-030 SHALL clear overflow when ov_clr=1; if overflow set and clear coincide, set wins.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously empty the FIFO, zero col/row, and drive pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, frame_done=0, overflow=0.
REQ-032 SHALL discard in-flight pixels on reset mid-frame; next output pixel after reset is col 0, row 0.

Configuration
REQ-033 SHALL, with macro EDGE_THRESH_EN defined, output pix_data=16'hFFFF if m>=thresh else 16'h0000.
REQ-034 SHALL, without EDGE_THRESH_EN, ignore thresh and use the REQ-025 grayscale mapping.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=4)
REQ-035 SHALL verify: pix_ready=1, magnitudes 0x00,0x80,0xFF,0x47 on consecutive cycles -> pix_data 0x0000,0x8410,0xFFFF,0x4228, first beat 2 edges after first write, pix_sof on first, pix_eol on fourth.
REQ-036 SHALL verify: pix_ready=0, 5 consecutive writes -> FIFO 4 entries plus output register holds first; overflow=0; 6th write -> dropped, overflow=1; ov_clr -> 0.
REQ-037 SHALL verify: pix_ready toggled 1,0,0,1 during 8-pixel stream -> pix_data stable while stalled, 8 handshakes in order, frame_done one pulse after 8th, next pixel asserts pix_sof.
REQ-038 SHALL verify: EDGE_THRESH_EN defined, thresh=0x40, magnitudes 0x3F,0x40,0xC0 -> 0x0000,0xFFFF,0xFFFF.
REQ-039 SHALL verify: rst_n low after 3 accepted pixels with 2 buffered -> all outputs 0 immediately, next accepted pixel after reset release has pix_sof=1.
